// File: rtl/adc_ad7980_pkg.sv
// ============================================================================
//  Module   : adc_ad7980_pkg
//  Purpose  : Shared types and helpers for the AD7980-style ADC reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_ad7980_pkg;

    // Reader sequencing: wait for trigger, hold CNV, clock the result out, hand it off
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        READ  = 2'd2,
        STORE = 2'd3
    } adc_state_t;

    // Shortest sample period that keeps every trigger landing in IDLE:
    // CONV cycles + full SCK burst + STORE cycle + the IDLE cycle that sees the trigger.
    function automatic int min_period(input int conv, input int div, input int w);
        return conv + 2 * div * w + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
//  Module   : spi_sclk_gen
//  Purpose  : SPI clock generator. A start pulse launches a free-running SCK
//             (CLK_DIV cycles low, then CLK_DIV cycles high, repeating) until
//             stop. rise_stb/fall_stb flag the cycle whose closing mclk edge
//             moves sclk 0->1 / 1->0, so a consumer can act on that same edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic mclk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int             CW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  C_DIV_LAST = CW'(CLK_DIV - 1);

    logic          r_active;
    logic [CW-1:0] r_div_cnt;
    logic          r_sclk;
    logic          w_edge;

    assign w_edge   = r_active && (r_div_cnt == C_DIV_LAST);
    assign rise_stb = w_edge && !r_sclk;
    assign fall_stb = w_edge &&  r_sclk;
    assign sclk     = r_sclk;

    // Half-period divider; stop (and reset) forces sclk back to its idle-low level
    always_ff @(posedge mclk) begin
        if (rst || stop) begin
            r_active  <= 1'b0;
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (start) begin
            r_active  <= 1'b1;
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else if (r_active) begin
            if (w_edge) begin
                r_div_cnt <= '0;
                r_sclk    <= ~r_sclk;
            end else begin
                r_div_cnt <= r_div_cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_ad7980_reader.sv
// ============================================================================
//  Module   : adc_ad7980_reader
//  Purpose  : 3-wire SPI master for an AD7980-style 16-bit ADC. A sample timer
//             paces conversions; each one raises CNV, clocks the result out
//             MSB first and offers it on an AXI-Stream master port. A sample
//             that completes while the previous one is still unaccepted is
//             dropped and flagged on overrun.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_ad7980_reader
    import adc_ad7980_pkg::*;
#(
    parameter int DATA_W        = 16,
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 36,
    // Tightest legal period for the other defaults (36 + 64 + 2)
    parameter int SAMPLE_PERIOD = 102
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              en,
    output logic              cnv,
    output logic              sclk,
    input  logic              miso,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic [DATA_W-1:0] m_axis_data,
    output logic              overrun
);

    localparam int TW  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CCW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int BW  = $clog2(DATA_W + 1);

    localparam logic [TW-1:0]  C_TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CCW-1:0] C_CONV_LAST  = CCW'(CONV_CYCLES - 1);
    localparam logic [BW-1:0]  C_BITS       = BW'(DATA_W);

    generate
        if (SAMPLE_PERIOD < min_period(CONV_CYCLES, CLK_DIV, DATA_W) ||
            CLK_DIV < 1 || DATA_W < 2 || CONV_CYCLES < 1) begin : g_param_check
            $fatal(1, "adc_ad7980_reader: illegal parameter set");
        end
    endgenerate

    adc_state_t        r_state;
    logic [TW-1:0]     r_timer;
    logic [CCW-1:0]    r_conv_cnt;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_cnv;
    logic              r_overrun;

    logic w_trigger;
    logic w_sclk_start;
    logic w_sclk_stop;
    logic w_rise;
    logic w_fall;

    assign w_trigger    = en && (r_timer == C_TIMER_LAST);
    // SCK starts so that the first READ cycle is its first low cycle
    assign w_sclk_start = (r_state == CONV) && (r_conv_cnt == C_CONV_LAST);
    // The last falling edge ends the burst and leaves sclk idling low
    assign w_sclk_stop  = (r_state == READ) && w_fall && (r_bit_cnt == C_BITS);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .mclk     (mclk),
        .rst      (rst),
        .start    (w_sclk_start),
        .stop     (w_sclk_stop),
        .sclk     (sclk),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    // Free-running sample timer, parked at zero while disabled
    always_ff @(posedge mclk) begin
        if (rst || !en) begin
            r_timer <= '0;
        end else if (r_timer == C_TIMER_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Conversion sequencer plus the AXI-Stream output register
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnv      <= 1'b0;
            r_conv_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && m_axis_ready) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_state    <= CONV;
                        r_cnv      <= 1'b1;
                        r_conv_cnt <= '0;
                    end
                end
                CONV: begin
                    if (r_conv_cnt == C_CONV_LAST) begin
                        r_cnv     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= READ;
                    end else begin
                        r_conv_cnt <= r_conv_cnt + CCW'(1);
                    end
                end
                READ: begin
                    // SDO is stable across the rising edge; it changes on the fall
                    if (w_rise) begin
                        r_shift   <= {r_shift[DATA_W-2:0], miso};
                        r_bit_cnt <= r_bit_cnt + BW'(1);
                    end
                    if (w_sclk_stop) begin
                        r_state <= STORE;
                    end
                end
                STORE: begin
                    // Load when the slot is empty or is being emptied this cycle
                    if (!r_valid || m_axis_ready) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The period check should make a busy-time trigger impossible; flag it if it happens
    always_ff @(posedge mclk) begin
        if (!rst) begin
            assert (!(w_trigger && (r_state != IDLE)))
                else $error("adc_ad7980_reader: sample trigger while conversion in progress");
        end
    end
`endif

    assign cnv          = r_cnv;
    assign m_axis_valid = r_valid;
    assign m_axis_data  = r_data;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_adc_ad7980_reader.sv
// ============================================================================
//  Module   : tb_adc_ad7980_reader
//  Purpose  : Self-checking bench for adc_ad7980_reader with an ADC pin model
//             and a scoreboard of expected stream beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_ad7980_reader;

    localparam int DW     = 16;
    localparam int DIV    = 2;
    localparam int CONV_C = 36;
    localparam int SP     = 102;

    logic          mclk = 1'b0;
    logic          rst;
    logic          en;
    logic          cnv;
    logic          sclk;
    logic          miso = 1'b0;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          overrun;

    int n_checks = 0;
    int n_pass   = 0;

    adc_ad7980_reader #(
        .DATA_W        (DW),
        .CLK_DIV       (DIV),
        .CONV_CYCLES   (CONV_C),
        .SAMPLE_PERIOD (SP)
    ) dut (
        .mclk         (mclk),
        .rst          (rst),
        .en           (en),
        .cnv          (cnv),
        .sclk         (sclk),
        .miso         (miso),
        .m_axis_valid (valid),
        .m_axis_ready (ready),
        .m_axis_data  (data),
        .overrun      (overrun)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- ADC pin model ----------------
    logic [DW-1:0] adc_vals[$];
    logic [DW-1:0] adc_word = '0;
    int            bit_idx  = 0;

    always @(negedge cnv) begin
        bit_idx = DW - 1;
        miso    = adc_word[bit_idx];
    end

    always @(negedge sclk) begin
        if (bit_idx > 0) bit_idx--;
        miso = adc_word[bit_idx];
    end

    // ---------------- reference model + monitor ----------------
    logic [DW-1:0] exp_q[$];
    bit            exp_ovr = 0;
    bit            armed = 0;
    bit            pend = 0;
    int            pend_pt = 0;
    logic [DW-1:0] pend_val = '0;
    int            pt = 0;
    bit            prev_cnv = 0, prev_sclk = 0, prev_valid = 0;
    int            cnv_hi = 0, cnv_rise_pt = 0, rise_cnt = 0, last_rise_pt = 0;
    int            beats = 0, ovr_count = 0, cnv_rises = 0;
    int            vrise_q[$];

    always @(negedge mclk) begin
        bit store_now;
        #1;
        pt++;
        if (armed) begin
            if (exp_q.size() > 0)
                chk(valid === 1'b1 && data === exp_q[0], "beat", {valid, data}, {1'b1, exp_q[0]});
            else
                chk(valid === 1'b0, "valid_idle", valid, 0);
            chk(overrun === exp_ovr, "overrun", overrun, exp_ovr);
            if (cnv === 1'b1) chk(sclk === 1'b0, "sclk_in_conv", sclk, 0);

            if (valid && ready) beats++;
            if (overrun) ovr_count++;
            if (valid && !prev_valid) vrise_q.push_back(pt);
            if (cnv && !prev_cnv) begin
                cnv_rises++;
                cnv_rise_pt = pt;
                cnv_hi      = 0;
                rise_cnt    = 0;
                adc_word    = (adc_vals.size() > 0) ? adc_vals.pop_front() : DW'($urandom);
                pend        = 1;
                pend_pt     = pt + CONV_C + 2 * DIV * DW;
                pend_val    = adc_word;
            end
            if (cnv) cnv_hi++;
            if (!cnv && prev_cnv) chk(cnv_hi == CONV_C, "cnv_width", cnv_hi, CONV_C);
            if (sclk && !prev_sclk) begin
                if (rise_cnt == 0)
                    chk(pt - cnv_rise_pt == CONV_C + DIV, "first_sclk_rise", pt - cnv_rise_pt, CONV_C + DIV);
                else
                    chk(pt - last_rise_pt == 2 * DIV, "sclk_period", pt - last_rise_pt, 2 * DIV);
                rise_cnt++;
                last_rise_pt = pt;
            end
        end
        prev_cnv   = cnv;
        prev_sclk  = sclk;
        prev_valid = valid;

        // Predict the effect of the coming edge from the inputs now applied
        exp_ovr = 0;
        if (rst) begin
            exp_q.delete();
            pend       = 0;
            prev_cnv   = 0;
            prev_sclk  = 0;
            prev_valid = 0;
            armed      = 1;
        end else if (armed) begin
            store_now = pend && (pt == pend_pt);
            if (exp_q.size() > 0 && ready) void'(exp_q.pop_front());
            if (store_now) begin
                pend = 0;
                chk(rise_cnt == DW, "sclk_rises", rise_cnt, DW);
                if (exp_q.size() == 0) exp_q.push_back(pend_val);
                else exp_ovr = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic wait_cnv_rises(input int target, input int budget, input string name);
        int k = 0;
        while (cnv_rises < target && k < budget) begin
            @(negedge mclk);
            k++;
        end
        chk(cnv_rises >= target, name, cnv_rises, target);
    endtask

    task automatic wait_cnv_low(input string name);
        int k = 0;
        while (cnv !== 1'b0 && k < 100) begin
            @(negedge mclk);
            k++;
        end
        chk(cnv === 1'b0, name, cnv, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b0, o0, r0, v0;
        rst   = 1'b1;
        en    = 1'b0;
        ready = 1'b1;
        cycles(3);
        #2;
        chk(cnv === 1'b0,     "rst_cnv",     cnv, 0);
        chk(sclk === 1'b0,    "rst_sclk",    sclk, 0);
        chk(valid === 1'b0,   "rst_valid",   valid, 0);
        chk(data === '0,      "rst_data",    data, 0);
        chk(overrun === 1'b0, "rst_overrun", overrun, 0);
        @(negedge mclk);
        rst = 1'b0;

        // 1: single CAFE conversion
        b0 = beats;
        adc_vals.push_back(16'hCAFE);
        r0 = cnv_rises;
        en = 1'b1;
        wait_cnv_rises(r0 + 1, SP + 20, "t1_cnv_start");
        en = 1'b0;
        cycles(250);
        chk(beats - b0 == 1, "t1_beats", beats - b0, 1);

        // 2: three back-to-back samples, strict period
        b0 = beats; o0 = ovr_count; r0 = cnv_rises; v0 = vrise_q.size();
        adc_vals.push_back(16'hBEEF);
        adc_vals.push_back(16'hFACE);
        adc_vals.push_back(16'hC0DE);
        en = 1'b1;
        wait_cnv_rises(r0 + 3, 3 * SP + 20, "t2_cnv_start");
        en = 1'b0;
        cycles(250);
        chk(beats - b0 == 3, "t2_beats", beats - b0, 3);
        chk(ovr_count == o0, "t2_no_overrun", ovr_count - o0, 0);
        chk(vrise_q.size() - v0 == 3, "t2_valid_rises", vrise_q.size() - v0, 3);
        if (vrise_q.size() - v0 == 3) begin
            chk(vrise_q[v0 + 1] - vrise_q[v0] == SP, "t2_spacing_a", vrise_q[v0 + 1] - vrise_q[v0], SP);
            chk(vrise_q[v0 + 2] - vrise_q[v0 + 1] == SP, "t2_spacing_b", vrise_q[v0 + 2] - vrise_q[v0 + 1], SP);
        end

        // 3: back-pressure, second sample dropped
        b0 = beats; o0 = ovr_count; r0 = cnv_rises;
        ready = 1'b0;
        adc_vals.push_back(16'hCAFE);
        adc_vals.push_back(16'hBEEF);
        en = 1'b1;
        wait_cnv_rises(r0 + 2, 2 * SP + 20, "t3_cnv_start");
        en = 1'b0;
        cycles(120);
        chk(ovr_count - o0 == 1, "t3_overrun_once", ovr_count - o0, 1);
        chk(beats == b0, "t3_no_beat_while_stalled", beats - b0, 0);
        ready = 1'b1;
        cycles(20);
        chk(beats - b0 == 1, "t3_single_delivery", beats - b0, 1);

        // 4: en dropped mid-read
        r0 = cnv_rises;
        en = 1'b1;
        wait_cnv_rises(r0 + 1, SP + 20, "t4_cnv_start");
        wait_cnv_low("t4_cnv_fall");
        cycles(10);
        en = 1'b0;
        b0 = beats;
        r0 = cnv_rises;
        cycles(500);
        chk(beats - b0 == 1, "t4_delivered", beats - b0, 1);
        chk(cnv_rises == r0, "t4_no_more_cnv", cnv_rises - r0, 0);

        // 5: reset mid-read aborts, then sampling resumes
        r0 = cnv_rises;
        en = 1'b1;
        wait_cnv_rises(r0 + 1, SP + 20, "t5_cnv_start");
        wait_cnv_low("t5_cnv_fall");
        cycles(20);
        b0  = beats;
        rst = 1'b1;
        @(negedge mclk);
        rst = 1'b0;
        #1;
        chk(cnv === 1'b0,   "t5_rst_cnv",   cnv, 0);
        chk(sclk === 1'b0,  "t5_rst_sclk",  sclk, 0);
        chk(valid === 1'b0, "t5_rst_valid", valid, 0);
        r0 = cnv_rises;
        wait_cnv_rises(r0 + 2, 2 * SP + 20, "t5_resume");
        en = 1'b0;
        cycles(250);
        chk(beats - b0 == 2, "t5_beats_after_rst", beats - b0, 2);

        // 6: ready toggling every cycle, random sample values
        b0 = beats; o0 = ovr_count; r0 = cnv_rises;
        en = 1'b1;
        for (int k = 0; k < 6 * SP + 300; k++) begin
            @(negedge mclk);
            ready = ~ready;
            if (cnv_rises >= r0 + 6) en = 1'b0;
        end
        ready = 1'b1;
        cycles(10);
        chk(beats - b0 == 6, "t6_beats", beats - b0, 6);
        chk(ovr_count == o0, "t6_no_overrun", ovr_count - o0, 0);

        // 7: sparse random ready, overruns predicted by the model
        r0 = cnv_rises;
        en = 1'b1;
        for (int k = 0; k < 8 * SP + 300; k++) begin
            @(negedge mclk);
            ready = ($urandom_range(0, 15) == 0);
            if (cnv_rises >= r0 + 8) en = 1'b0;
        end

        // Drain
        en    = 1'b0;
        ready = 1'b1;
        cycles(250);
        chk(exp_q.size() == 0, "drain_scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
